// File: rtl/l2_cache.sv
// l2_cache: unified 2-way set-associative, write-back, write-allocate L2.
// One L1 request at a time; misses go to backing memory over a valid/ready
// request channel with a read-data strobe. Per-set 1-bit LRU names the next victim.
module l2_cache #(
  parameter int unsigned CACHE_SIZE    = 16384,
  parameter int unsigned BLOCK_SIZE    = 4,
  parameter int unsigned ASSOCIATIVITY = 2,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  l1_req_valid,
  input  logic [31:0]           l1_req_addr,
  input  logic                  l1_req_op,
  input  logic [DATA_WIDTH-1:0] l1_write_data,
  output logic                  l2_resp_valid,
  output logic [DATA_WIDTH-1:0] l2_resp_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [31:0]           mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);

  localparam int unsigned NUM_SETS     = CACHE_SIZE / (BLOCK_SIZE * ASSOCIATIVITY);
  localparam int unsigned INDEX_WIDTH  = $clog2(NUM_SETS);
  localparam int unsigned OFFSET_WIDTH = $clog2(BLOCK_SIZE);
  localparam int unsigned TAG_WIDTH    = 32 - INDEX_WIDTH - OFFSET_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOOKUP, ST_EVICT, ST_REFILL_REQ, ST_REFILL_WAIT, ST_RESP
  } state_t;

  state_t state_q, state_d;

  // Line storage: tag/data are plain arrays, valid/dirty/lru are reset flops.
  logic [TAG_WIDTH-1:0]     tag_arr  [ASSOCIATIVITY][NUM_SETS];
  logic [DATA_WIDTH-1:0]    data_arr [ASSOCIATIVITY][NUM_SETS];
  logic [NUM_SETS-1:0][1:0] valid_q;
  logic [NUM_SETS-1:0][1:0] dirty_q;
  logic [NUM_SETS-1:0]      lru_q;

  // Captured request and chosen victim.
  logic [TAG_WIDTH-1:0]   req_tag;
  logic [INDEX_WIDTH-1:0] req_index;
  logic                   req_op;
  logic [DATA_WIDTH-1:0]  req_wdata;
  logic                   victim_q;

  // Byte offset within the single-word line carries no information.
  logic unused_offset;
  assign unused_offset = ^l1_req_addr[OFFSET_WIDTH-1:0];

  // Tag compare and victim selection for the captured set.
  logic [1:0] way_valid;
  logic [1:0] way_hit;
  logic       hit_way;
  logic       victim_c;
  logic       victim_dirty;
  logic       evict_way;

  assign way_valid    = valid_q[req_index];
  assign way_hit[0]   = way_valid[0] && (tag_arr[0][req_index] == req_tag);
  assign way_hit[1]   = way_valid[1] && (tag_arr[1][req_index] == req_tag);
  assign hit_way      = way_hit[0] ? 1'b0 : 1'b1;
  assign victim_c     = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru_q[req_index]);
  assign victim_dirty = way_valid[victim_c] && dirty_q[req_index][victim_c];
  assign evict_way    = (state_q == ST_LOOKUP) ? victim_c : victim_q;

  // Next-state, line-update controls and next values of the registered outputs.
  logic                  line_we, line_way, line_dirty, lru_we, lru_val;
  logic [DATA_WIDTH-1:0] line_data, resp_data_d, mem_wdata_d;
  logic                  hit_inc, miss_inc, mem_valid_d, mem_we_d;
  logic [31:0]           mem_addr_d;

  always_comb begin
    state_d     = state_q;
    resp_data_d = l2_resp_data;
    line_we     = 1'b0;
    line_way    = victim_q;
    line_data   = req_wdata;
    line_dirty  = 1'b1;
    lru_we      = 1'b0;
    lru_val     = 1'b0;
    hit_inc     = 1'b0;
    miss_inc    = 1'b0;
    mem_valid_d = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (l1_req_valid) state_d = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (|way_hit) begin
          hit_inc = 1'b1;
          lru_we  = 1'b1;
          lru_val = ~hit_way;
          state_d = ST_RESP;
          if (req_op) begin
            line_we     = 1'b1;
            line_way    = hit_way;
            resp_data_d = req_wdata;
          end else begin
            resp_data_d = data_arr[hit_way][req_index];
          end
        end else begin
          miss_inc = 1'b1;
          if (victim_dirty) begin
            state_d = ST_EVICT;
          end else if (!req_op) begin
            state_d = ST_REFILL_REQ;
          end else begin
            line_we     = 1'b1;
            line_way    = victim_c;
            lru_we      = 1'b1;
            lru_val     = ~victim_c;
            resp_data_d = req_wdata;
            state_d     = ST_RESP;
          end
        end
      end
      ST_EVICT: begin
        if (mem_req_ready) begin
          if (!req_op) begin
            state_d = ST_REFILL_REQ;
          end else begin
            line_we     = 1'b1;
            lru_we      = 1'b1;
            lru_val     = ~victim_q;
            resp_data_d = req_wdata;
            state_d     = ST_RESP;
          end
        end
      end
      ST_REFILL_REQ: begin
        if (mem_req_ready) state_d = ST_REFILL_WAIT;
      end
      ST_REFILL_WAIT: begin
        if (mem_resp_valid) begin
          line_we     = 1'b1;
          line_data   = mem_rdata;
          line_dirty  = 1'b0;
          lru_we      = 1'b1;
          lru_val     = ~victim_q;
          resp_data_d = mem_rdata;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (state_d == ST_EVICT) begin
      mem_valid_d = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = {tag_arr[evict_way][req_index], req_index, {OFFSET_WIDTH{1'b0}}};
      mem_wdata_d = data_arr[evict_way][req_index];
    end else if (state_d == ST_REFILL_REQ) begin
      mem_valid_d = 1'b1;
      mem_addr_d  = {req_tag, req_index, {OFFSET_WIDTH{1'b0}}};
    end
  end

  // State register, registered outputs and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      l2_resp_valid <= 1'b0;
      l2_resp_data  <= '0;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_wdata     <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
    end else begin
      state_q       <= state_d;
      l2_resp_valid <= (state_d == ST_RESP);
      l2_resp_data  <= resp_data_d;
      mem_req_valid <= mem_valid_d;
      mem_req_we    <= mem_we_d;
      mem_req_addr  <= mem_addr_d;
      mem_wdata     <= mem_wdata_d;
      if (hit_inc)  hit_count  <= hit_count + 32'd1;
      if (miss_inc) miss_count <= miss_count + 32'd1;
    end
  end

  // Request capture in IDLE and victim capture in LOOKUP.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_tag   <= '0;
      req_index <= '0;
      req_op    <= 1'b0;
      req_wdata <= '0;
      victim_q  <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && l1_req_valid) begin
        req_tag   <= l1_req_addr[31 -: TAG_WIDTH];
        req_index <= l1_req_addr[OFFSET_WIDTH +: INDEX_WIDTH];
        req_op    <= l1_req_op;
        req_wdata <= l1_write_data;
      end
      if (state_q == ST_LOOKUP) victim_q <= victim_c;
    end
  end

  // Valid/dirty/LRU state, cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
      lru_q   <= '0;
    end else begin
      if (line_we) begin
        valid_q[req_index][line_way] <= 1'b1;
        dirty_q[req_index][line_way] <= line_dirty;
      end
      if (lru_we) lru_q[req_index] <= lru_val;
    end
  end

  // Tag and data arrays.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_arr[line_way][req_index]  <= req_tag;
      data_arr[line_way][req_index] <= line_data;
    end
  end

endmodule

// File: tb/tb_l2_cache.sv
// tb_l2_cache: directed plus randomized checks of l2_cache against a behavioural cache model.
`timescale 1ns/1ps
module tb_l2_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        l1_req_valid = 1'b0;
  logic [31:0] l1_req_addr = '0;
  logic        l1_req_op = 1'b0;
  logic [31:0] l1_write_data = '0;
  logic        l2_resp_valid;
  logic [31:0] l2_resp_data;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_wdata;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  l2_cache dut (
    .clk(clk), .rst(rst),
    .l1_req_valid(l1_req_valid), .l1_req_addr(l1_req_addr), .l1_req_op(l1_req_op),
    .l1_write_data(l1_write_data),
    .l2_resp_valid(l2_resp_valid), .l2_resp_data(l2_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned checks = 0;
  int unsigned failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Backing memory: the responder's copy and the model's copy.
  logic [31:0] mem     [int unsigned];
  logic [31:0] ref_mem [int unsigned];

  function automatic logic [31:0] mem_default(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'hA5A5_0000;
  endfunction

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int unsigned first;
    int unsigned acc;
  } tx_t;

  tx_t obs_q[$];
  tx_t exp_q[$];

  // Memory responder and channel monitors.
  int unsigned stall_left = 0;
  int unsigned resp_delay_fix = 0;
  int          resp_cnt = -1;
  logic [31:0] resp_addr = '0;
  int unsigned mresp_cyc = 0;
  bit          trk = 1'b0;
  int unsigned trk_first = 0;
  bit          prev_stall = 1'b0;
  logic        prev_we = 1'b0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;
  int unsigned stab_err = 0, zero_err = 0, resp_pulses = 0;

  initial begin
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          mem_resp_valid = 1'b1;
          mem_rdata = mem.exists(resp_addr) ? mem[resp_addr] : mem_default(resp_addr);
          mresp_cyc = cyc;
          resp_cnt = -1;
        end
      end
      if (prev_stall && (mem_req_valid !== 1'b1 || mem_req_we !== prev_we ||
                         mem_req_addr !== prev_addr || mem_wdata !== prev_wdata))
        stab_err++;
      if (!mem_req_valid && (mem_req_we || mem_req_addr != 0 || mem_wdata != 0)) zero_err++;
      if (l2_resp_valid) resp_pulses++;
      if (mem_req_valid) begin
        if (!trk) begin
          trk = 1'b1;
          trk_first = cyc;
        end
        if (stall_left > 0) begin
          mem_req_ready = 1'b0;
          stall_left--;
        end else begin
          mem_req_ready = ($urandom_range(0, 2) != 0);
        end
        if (mem_req_ready) begin
          obs_q.push_back('{mem_req_we, mem_req_addr, mem_wdata, trk_first, cyc});
          trk = 1'b0;
          if (mem_req_we) begin
            mem[mem_req_addr] = mem_wdata;
          end else begin
            resp_addr = mem_req_addr;
            resp_cnt = (resp_delay_fix != 0) ? int'(resp_delay_fix) : int'($urandom_range(1, 3));
          end
        end
      end else begin
        mem_req_ready = ($urandom_range(0, 1) != 0);
      end
      prev_stall = mem_req_valid && !mem_req_ready;
      prev_we    = mem_req_we;
      prev_addr  = mem_req_addr;
      prev_wdata = mem_wdata;
    end
  end

  // Behavioural cache model: per-set line records and a victim pointer.
  bit          m_valid [0:2047][0:1];
  bit          m_dirty [0:2047][0:1];
  logic [18:0] m_tag   [0:2047][0:1];
  logic [31:0] m_data  [0:2047][0:1];
  int          m_victim[0:2047];
  int unsigned m_hits = 0, m_misses = 0;

  task automatic model_reset();
    for (int s = 0; s < 2048; s++) begin
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
      m_victim[s] = 0;
    end
    m_hits = 0;
    m_misses = 0;
  endtask

  task automatic model_access(input bit op, input logic [31:0] addr, input logic [31:0] wd,
                              output logic [31:0] rdata, output bit hit);
    int          set;
    int          way;
    logic [18:0] tag;
    logic [31:0] line;
    set  = int'(addr[12:2]);
    tag  = addr[31:13];
    line = {addr[31:2], 2'b00};
    way  = -1;
    for (int w = 0; w < 2; w++)
      if (way < 0 && m_valid[set][w] && m_tag[set][w] == tag) way = w;
    hit = (way >= 0);
    if (hit) begin
      m_hits++;
      if (op) begin
        m_data[set][way]  = wd;
        m_dirty[set][way] = 1'b1;
      end
      rdata = m_data[set][way];
    end else begin
      m_misses++;
      if (!m_valid[set][0]) way = 0;
      else if (!m_valid[set][1]) way = 1;
      else way = m_victim[set];
      if (m_valid[set][way] && m_dirty[set][way]) begin
        exp_q.push_back('{1'b1, {m_tag[set][way], addr[12:2], 2'b00}, m_data[set][way], 0, 0});
        ref_mem[{m_tag[set][way], addr[12:2], 2'b00}] = m_data[set][way];
      end
      if (op) begin
        rdata = wd;
        m_dirty[set][way] = 1'b1;
      end else begin
        exp_q.push_back('{1'b0, line, 32'h0, 0, 0});
        rdata = ref_mem.exists(line) ? ref_mem[line] : mem_default(line);
        m_dirty[set][way] = 1'b0;
      end
      m_data[set][way]  = rdata;
      m_valid[set][way] = 1'b1;
      m_tag[set][way]   = tag;
    end
    m_victim[set] = 1 - way;
  endtask

  int unsigned n_req = 0;

  // One L1 request, checked against the model.
  task automatic do_req(input bit op, input logic [31:0] addr, input logic [31:0] wd, input string tag);
    logic [31:0] exp_data;
    bit          exp_hit;
    bit          got;
    int unsigned c0, rc;
    exp_q.delete();
    obs_q.delete();
    model_access(op, addr, wd, exp_data, exp_hit);
    @(negedge clk);
    l1_req_valid = 1'b1;
    l1_req_addr = addr;
    l1_req_op = op;
    l1_write_data = wd;
    c0 = cyc;
    got = 1'b0;
    rc = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (l2_resp_valid) begin
        got = 1'b1;
        rc = cyc;
      end
    end
    l1_req_valid = 1'b0;
    n_req++;
    check({tag, "/resp_seen"}, 32'(got), 32'd1);
    if (!got) return;
    check({tag, "/data"}, l2_resp_data, exp_data);
    check({tag, "/hits"}, hit_count, m_hits);
    check({tag, "/misses"}, miss_count, m_misses);
    check({tag, "/ntx"}, 32'(obs_q.size()), 32'(exp_q.size()));
    if (obs_q.size() == exp_q.size()) begin
      foreach (exp_q[k]) begin
        check({tag, "/tx_we"}, 32'(obs_q[k].we), 32'(exp_q[k].we));
        check({tag, "/tx_addr"}, obs_q[k].addr, exp_q[k].addr);
        if (exp_q[k].we) check({tag, "/tx_wdata"}, obs_q[k].wdata, exp_q[k].wdata);
      end
      if (exp_q.size() == 0) check({tag, "/lat"}, rc - c0, 32'd2);
      else check({tag, "/memreq_lat"}, obs_q[0].first - c0, 32'd2);
      if (exp_q.size() == 2) check({tag, "/refill_after_wb"}, obs_q[1].first, obs_q[0].acc + 1);
      if (exp_q.size() > 0 && !exp_q[exp_q.size()-1].we)
        check({tag, "/refill_lat"}, rc, mresp_cyc + 1);
    end
    @(negedge clk);
    check({tag, "/pulse_end"}, 32'(l2_resp_valid), 32'd0);
    check({tag, "/data_hold"}, l2_resp_data, exp_data);
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  // Reset asserted while the cache waits for refill data.
  task automatic reset_in_refill_wait(input logic [31:0] addr);
    bit          seen;
    int unsigned late;
    obs_q.delete();
    resp_delay_fix = 4;
    @(negedge clk);
    l1_req_valid = 1'b1;
    l1_req_addr = addr;
    l1_req_op = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (obs_q.size() > 0) seen = 1'b1;
    end
    check("rst/refill_accepted", 32'(seen), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    l1_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst/resp_valid", 32'(l2_resp_valid), 32'd0);
    check("rst/resp_data", l2_resp_data, 32'd0);
    check("rst/mem_valid", 32'(mem_req_valid), 32'd0);
    check("rst/hits", hit_count, 32'd0);
    check("rst/misses", miss_count, 32'd0);
    late = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (l2_resp_valid || mem_req_valid) late++;
    end
    check("rst/no_activity_after", late, 32'd0);
    resp_delay_fix = 0;
    model_reset();
  endtask

  initial begin
    bit          op;
    logic [31:0] a;
    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset/resp_valid", 32'(l2_resp_valid), 32'd0);
    check("reset/resp_data", l2_resp_data, 32'd0);
    check("reset/mem_valid", 32'(mem_req_valid), 32'd0);
    check("reset/mem_addr", mem_req_addr, 32'd0);
    check("reset/hits", hit_count, 32'd0);
    check("reset/misses", miss_count, 32'd0);
    rst = 1'b0;

    preload(32'h0000_1000, 32'hCAFE_0001);
    do_req(1'b0, 32'h0000_1000, 32'h0, "rd_miss_1000");
    check("rd_miss_1000/const", l2_resp_data, 32'hCAFE_0001);
    do_req(1'b0, 32'h0000_1000, 32'h0, "rd_hit_1000");
    check("rd_hit_1000/hit_count", hit_count, 32'd1);
    do_req(1'b1, 32'h0000_2000, 32'h1234_5678, "wr_cold_2000");
    do_req(1'b0, 32'h0000_2000, 32'h0, "rd_hit_2000");
    check("rd_hit_2000/const", l2_resp_data, 32'h1234_5678);
    do_req(1'b1, 32'h0000_0000, 32'h0BAD_F00D, "wr_miss_0000");
    do_req(1'b1, 32'h0000_2000, 32'h2222_2222, "wr_hit_2000");
    do_req(1'b0, 32'h0000_0000, 32'h0, "touch_0000");
    do_req(1'b0, 32'h0000_4000, 32'h0, "dirty_rd_4000");
    do_req(1'b0, 32'h0000_0000, 32'h0, "retained_0000");
    check("retained_0000/const", l2_resp_data, 32'h0BAD_F00D);

    stall_left = 5;
    do_req(1'b0, 32'h0000_6010, 32'h0, "stall_refill");
    if (obs_q.size() > 0) check("stall_refill/stalled", 32'(obs_q[0].acc - obs_q[0].first >= 5), 32'd1);

    reset_in_refill_wait(32'h0000_E190);
    do_req(1'b0, 32'h0000_E190, 32'h0, "after_rst_miss");
    check("after_rst_miss/misses", miss_count, 32'd1);

    for (int n = 0; n < 400; n++) begin
      op = ($urandom_range(0, 1) != 0);
      a  = (32'($urandom_range(0, 5)) << 13) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      do_req(op, a, $urandom, "rand");
    end

    @(negedge clk);
    check("final/stable_while_stalled", stab_err, 32'd0);
    check("final/zero_when_idle", zero_err, 32'd0);
    check("final/resp_pulses", resp_pulses, n_req);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
